// File: rtl/io_map.sv
// Shared I/O map for the j1 UART receive path: decode addresses and drain FSM encoding.
package io_map;

    localparam logic [15:0] UART_RX    = 16'h1000;
    localparam logic [15:0] UART_STAT  = 16'h2000;
    localparam logic [15:0] UART_DROPS = 16'h2004;

    typedef enum logic {
        StIdle,
        StGuard
    } drain_state_e;

endpackage

// File: rtl/sync_fifo_mem.sv
// Register-array storage for the RX FIFO: one synchronous write port, one asynchronous read.
module sync_fifo_mem #(
    parameter int unsigned AW    = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [0:(1 << AW) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Drains buart RX bytes into a show-ahead FIFO for the j1 CPU.
// Define UART_RX_FIFO_STATS_EN to add the saturating drop_count output.
module uart_rx_fifo
    import io_map::*;
#(
    parameter int unsigned AW    = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             uart_valid,
    input  logic [WIDTH-1:0] uart_data,
    output logic             uart_rd,
    input  logic             cpu_pop,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_avail,
    output logic             rx_full,
    output logic [AW:0]      rx_level,
    output logic             overflow
`ifdef UART_RX_FIFO_STATS_EN
    ,
    output logic [15:0]      drop_count
`endif
);

    localparam logic [AW:0] PtrOne = (AW + 1)'(1);

    drain_state_e     state_q, state_d;
    logic [AW:0]      wptr_q, rptr_q, rptr_inc, level;
    logic [WIDTH-1:0] rx_data_q, rx_data_d, mem_rdata;
    logic             overflow_q;
    logic             empty, full, do_push, do_pop, drop;

    assign level    = wptr_q - rptr_q;
    assign empty    = (wptr_q == rptr_q);
    assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rptr_inc = rptr_q + PtrOne;

    // Ack is gated by reset so a byte offered during reset is re-drained afterwards.
    always_comb begin
        state_d = state_q;
        uart_rd = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (uart_valid && !reset) begin
                    uart_rd = 1'b1;
                    state_d = StGuard;
                end
            end
            StGuard: begin
                state_d = StIdle;
            end
        endcase
    end

    assign do_pop  = cpu_pop && !empty;
    assign do_push = uart_rd && (!full || cpu_pop);
    assign drop    = uart_rd && full && !cpu_pop;

    // Head register looks ahead one entry so a push or pop is visible the next cycle.
    always_comb begin
        rx_data_d = rx_data_q;
        if (do_push && (empty || (level == PtrOne && do_pop))) begin
            rx_data_d = uart_data;
        end else if (do_pop && level > PtrOne) begin
            rx_data_d = mem_rdata;
        end
    end

    sync_fifo_mem #(
        .AW    (AW),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (do_push),
        .waddr (wptr_q[AW-1:0]),
        .wdata (uart_data),
        .raddr (rptr_inc[AW-1:0]),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            wptr_q     <= '0;
            rptr_q     <= '0;
            rx_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_data_q <= rx_data_d;
            if (do_push) begin
                wptr_q <= wptr_q + PtrOne;
            end
            if (do_pop) begin
                rptr_q <= rptr_inc;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clr_ovf) begin
                overflow_q <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FIFO_STATS_EN
    logic [15:0] drop_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count_q <= '0;
        end else if (drop) begin
            if (clr_ovf) begin
                drop_count_q <= 16'd1;
            end else if (drop_count_q != 16'hFFFF) begin
                drop_count_q <= drop_count_q + 16'd1;
            end
        end else if (clr_ovf) begin
            drop_count_q <= '0;
        end
    end

    assign drop_count = drop_count_q;
`endif

    assign rx_data  = rx_data_q;
    assign rx_avail = !empty;
    assign rx_full  = full;
    assign rx_level = level;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: accepted bytes are queued, a monitor checks each pop.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset, uart_valid, uart_rd, cpu_pop, clr_ovf;
    logic [7:0] uart_data, rx_data;
    logic       rx_avail, rx_full, overflow;
    logic [4:0] rx_level;
`ifdef UART_RX_FIFO_STATS_EN
    logic [15:0] drop_count;
`endif

    int         total    = 0;
    int         bad      = 0;
    int         rd_count = 0;
    int         c0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    always #5 clk = ~clk;

    uart_rx_fifo dut (
        .clk        (clk),
        .reset      (reset),
        .uart_valid (uart_valid),
        .uart_data  (uart_data),
        .uart_rd    (uart_rd),
        .cpu_pop    (cpu_pop),
        .clr_ovf    (clr_ovf),
        .rx_data    (rx_data),
        .rx_avail   (rx_avail),
        .rx_full    (rx_full),
        .rx_level   (rx_level),
        .overflow   (overflow)
`ifdef UART_RX_FIFO_STATS_EN
        ,
        .drop_count (drop_count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: every effective pop must present the oldest expected byte.
    always @(negedge clk) begin
        if (uart_rd) rd_count++;
        if (cpu_pop && rx_avail) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got %0h want none", rx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (rx_data !== mon_exp) begin
                    bad++;
                    $display("FAIL pop_data: got %0h want %0h", rx_data, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop();
        cpu_pop = 1'b1;
        tick();
        cpu_pop = 1'b0;
    endtask

    // buart model: valid held through the guard cycle, dropped after it.
    task automatic push_byte(input logic [7:0] d, input bit accept, input bit with_pop);
        bit seen;
        seen       = 1'b0;
        uart_valid = 1'b1;
        uart_data  = d;
        cpu_pop    = with_pop;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (uart_rd) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL rd_timeout: got no uart_rd want pulse for %0h", d);
            uart_valid = 1'b0;
            cpu_pop    = 1'b0;
            tick();
            return;
        end
        if (accept) exp_q.push_back(d);
        tick();
        cpu_pop = 1'b0;
        @(negedge clk);
        chk("rd_one_cycle", 32'(uart_rd), 0);
        tick();
        uart_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        uart_valid = 1'b0;
        uart_data  = 8'h00;
        cpu_pop    = 1'b0;
        clr_ovf    = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_level", 32'(rx_level), 0);
        chk("rst_avail", 32'(rx_avail), 0);
        chk("rst_full", 32'(rx_full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_rd", 32'(uart_rd), 0);
        chk("rst_data", 32'(rx_data), 0);
        tick();
        reset = 1'b0;

        // Single byte latency
        push_byte(8'h41, 1'b1, 1'b0);
        @(negedge clk);
        chk("t1_avail", 32'(rx_avail), 1);
        chk("t1_data", 32'(rx_data), 32'h41);
        chk("t1_level", 32'(rx_level), 1);
        tick();
        pop();
        @(negedge clk);
        chk("t1_empty", 32'(rx_avail), 0);
        tick();

        // Fill to full
        for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b1, 1'b0);
        @(negedge clk);
        chk("t2_full", 32'(rx_full), 1);
        chk("t2_level", 32'(rx_level), 16);
        chk("t2_ovf", 32'(overflow), 0);
        tick();

        // Drop while full, then clear
        push_byte(8'hAA, 1'b0, 1'b0);
        @(negedge clk);
        chk("t3_ovf_set", 32'(overflow), 1);
        chk("t3_level", 32'(rx_level), 16);
        tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        @(negedge clk);
        chk("t3_ovf_clr", 32'(overflow), 0);
        tick();

        // Push with simultaneous pop while full
        push_byte(8'hBB, 1'b1, 1'b1);
        @(negedge clk);
        chk("t4_level", 32'(rx_level), 16);
        chk("t4_ovf", 32'(overflow), 0);
        tick();
        repeat (16) pop();
        @(negedge clk);
        chk("t4_empty", 32'(rx_avail), 0);
        chk("t4_level0", 32'(rx_level), 0);
        tick();

        // Pop on empty, then wrap pointers
        pop();
        @(negedge clk);
        chk("t5_level", 32'(rx_level), 0);
        chk("t5_avail", 32'(rx_avail), 0);
        tick();
        for (int i = 0; i < 40; i++) begin
            push_byte(8'(i * 7 + 3), 1'b1, 1'b0);
            pop();
        end
        @(negedge clk);
        chk("t5_wrap_level", 32'(rx_level), 0);
        tick();

        // Reset mid-operation with a pending byte
        for (int i = 0; i < 5; i++) push_byte(8'(8'hC0 + i), 1'b1, 1'b0);
        @(negedge clk);
        chk("t6_level5", 32'(rx_level), 5);
        tick();
        reset      = 1'b1;
        uart_valid = 1'b1;
        uart_data  = 8'h77;
        tick();
        reset = 1'b0;
        exp_q.delete();
        c0 = rd_count;
        @(negedge clk);
        chk("t6_level", 32'(rx_level), 0);
        chk("t6_avail", 32'(rx_avail), 0);
        chk("t6_redrain", 32'(uart_rd), 1);
        exp_q.push_back(8'h77);
        tick();
        @(negedge clk);
        chk("t6_guard", 32'(uart_rd), 0);
        tick();
        uart_valid = 1'b0;
        repeat (3) tick();
        chk("t6_once", 32'(rd_count - c0), 1);
        chk("t6_data", 32'(rx_data), 32'h77);
        chk("t6_level1", 32'(rx_level), 1);
        pop();
        @(negedge clk);
        chk("t6_empty", 32'(rx_avail), 0);
        tick();

`ifdef UART_RX_FIFO_STATS_EN
        for (int i = 0; i < 16; i++) push_byte(8'(8'h50 + i), 1'b1, 1'b0);
        repeat (3) push_byte(8'hEE, 1'b0, 1'b0);
        @(negedge clk);
        chk("st_drops", 32'(drop_count), 3);
        tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        @(negedge clk);
        chk("st_clear", 32'(drop_count), 0);
        tick();
        repeat (16) pop();
`endif

        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
